// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the layer-sequencing neural engine.
package nn_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_IN, S_FETCH, S_MAC, S_WRITE, S_DONE
  } state_e;

  // Fixed-point rescale, optional ReLU, then clamp into a signed data_w range.
  // Works on a 64-bit container so any legal accumulator width fits.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] acc,
                                                  input int frac, input logic relu,
                                                  input int data_w);
    logic signed [63:0] v, hi, lo;
    v  = acc >>> frac;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (relu && v < 64'sd0) v = '0;
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

  // Bank select flag: 0 reads the low bank and writes the high bank.
  function automatic logic bank_swap(input logic sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/neural_layer_engine_if.sv
// Host handshake plus instruction/weight/neuron memory ports of the engine.
interface neural_layer_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                     start, busy, done;
  logic signed [DATA_W-1:0] result;
  logic        [ADDR_W-1:0] result_base;
  logic        [ADDR_W-1:0] instr_addr, instr_data;
  logic        [ADDR_W-1:0] weight_addr;
  logic signed [DATA_W-1:0] weight_data;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic        [ADDR_W-1:0] wr_addr;
  logic signed [DATA_W-1:0] wr_data;

  modport master (
    input  start, instr_data, weight_data, rd_data,
    output busy, done, result, result_base, instr_addr, weight_addr,
           rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, instr_data, weight_data, rd_data,
    input  busy, done, result, result_base, instr_addr, weight_addr,
           rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/nn_mac_unit.sv
// Signed multiply-accumulate with the shift/ReLU/saturate output stage.
module nn_mac_unit import nn_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAC_BITS = 4,
  parameter int RELU_EN   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign y = DATA_W'(sat_relu(64'(acc_q), FRAC_BITS, RELU_EN != 0, DATA_W));
endmodule

// File: rtl/neural_layer_engine.sv
// Sequences fully connected layers from instruction memory, ping-ponging
// activations between two neuron-RAM banks.
module neural_layer_engine import nn_pkg::*; #(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FRAC_BITS  = 4,
  parameter int RELU_EN    = 1,
  parameter int MAX_LAYERS = 8,
  parameter int BANK_LOW   = 0,
  parameter int BANK_HIGH  = 128
) (
  input logic                   clk,
  input logic                   reset,
  neural_layer_engine_if.master bus
);
  state_e                   state_q, state_d;
  logic        [ADDR_W-1:0] ip_q, ip_d, w_ptr_q, w_ptr_d, i_q, i_d;
  logic        [ADDR_W-1:0] neuron_q, neuron_d, nk_q, nk_d, fanin_q, fanin_d;
  logic        [ADDR_W-1:0] rbase_q, rbase_d;
  logic                     bank_q, bank_d;
  logic signed [DATA_W-1:0] result_q, result_d, mac_y;
  logic                     mac_clr, mac_en, in_write, in_mac;
  logic        [ADDR_W-1:0] rd_base, wr_base;

  assign rd_base = bank_q ? ADDR_W'(BANK_HIGH) : ADDR_W'(BANK_LOW);
  assign wr_base = bank_q ? ADDR_W'(BANK_LOW)  : ADDR_W'(BANK_HIGH);

  nn_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS), .RELU_EN(RELU_EN)) u_mac (
    .clk(clk), .reset(reset), .clr(mac_clr), .en(mac_en),
    .a(bus.rd_data), .b(bus.weight_data), .y(mac_y)
  );

  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    w_ptr_d  = w_ptr_q;
    i_d      = i_q;
    neuron_d = neuron_q;
    nk_d     = nk_q;
    fanin_d  = fanin_q;
    rbase_d  = rbase_q;
    bank_d   = bank_q;
    result_d = result_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d  = S_FETCH_IN;
        ip_d     = '0;
        w_ptr_d  = '0;
        bank_d   = 1'b0;
        result_d = '0;
        rbase_d  = ADDR_W'(BANK_LOW);
      end
      S_FETCH_IN: begin
        fanin_d = bus.instr_data;
        ip_d    = ADDR_W'(1);
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.instr_data == '0 || ip_q > ADDR_W'(MAX_LAYERS)) begin
          state_d = S_DONE;
        end else begin
          nk_d     = bus.instr_data;
          neuron_d = '0;
          i_d      = '0;
          mac_clr  = 1'b1;
          state_d  = (fanin_q == '0) ? S_WRITE : S_MAC;
        end
      end
      S_MAC: begin
        mac_en  = 1'b1;
        w_ptr_d = w_ptr_q + 1'b1;
        if (i_q == fanin_q - 1'b1) state_d = S_WRITE;
        else                       i_d     = i_q + 1'b1;
      end
      S_WRITE: begin
        result_d = mac_y;
        if (neuron_q < nk_q - 1'b1) begin
          neuron_d = neuron_q + 1'b1;
          i_d      = '0;
          mac_clr  = 1'b1;
          state_d  = (fanin_q == '0) ? S_WRITE : S_MAC;
        end else begin
          // Layer finished: its outputs become the next layer's inputs.
          fanin_d = nk_q;
          bank_d  = bank_swap(bank_q);
          rbase_d = wr_base;
          ip_d    = ip_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ip_q     <= '0;
      w_ptr_q  <= '0;
      i_q      <= '0;
      neuron_q <= '0;
      nk_q     <= '0;
      fanin_q  <= '0;
      rbase_q  <= ADDR_W'(BANK_LOW);
      bank_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ip_q     <= ip_d;
      w_ptr_q  <= w_ptr_d;
      i_q      <= i_d;
      neuron_q <= neuron_d;
      nk_q     <= nk_d;
      fanin_q  <= fanin_d;
      rbase_q  <= rbase_d;
      bank_q   <= bank_d;
      result_q <= result_d;
    end
  end

  // Outputs decode straight from the state so reset clears them immediately.
  assign in_write        = (state_q == S_WRITE);
  assign in_mac          = (state_q == S_MAC);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.wr_en       = in_write;
  assign bus.wr_addr     = in_write ? wr_base + neuron_q : '0;
  assign bus.wr_data     = in_write ? mac_y : '0;
  assign bus.rd_addr     = in_mac ? rd_base + i_q : '0;
  assign bus.weight_addr = w_ptr_q;
  assign bus.instr_addr  = ip_q;
  assign bus.result      = result_q;
  assign bus.result_base = rbase_q;
endmodule

// File: doc/neural_layer_engine.md
Name: neural_layer_engine

Overview:
Parametrised successor to the fixed 8-bit accelerator. It sequences a multi-layer, fully connected network whose layer sizes come from an instruction memory. It reads activations from a ping-pong neuron RAM and weights from a weight ROM, accumulates signed products, then applies fixed-point shift, optional ReLU and saturation. Results are written back to the RAM, and a start/busy/done handshake lets a host CPU or testbench run whole inferences.

Parameters:
DATA_W, 8, signed activation/weight width
ACC_W, 24, signed accumulator width; must be ≥ 2*DATA_W+ADDR_W
ADDR_W, 8, width of all memory addresses and layer-size words
FRAC_BITS, 4, arithmetic right shift applied to accumulator before activation
RELU_EN, 1, 1 = clamp negative outputs to 0; 0 = linear
MAX_LAYERS, 8, hard cap on computed layers (instr index 1..MAX_LAYERS)
BANK_LOW, 0, base address of neuron bank A (holds network inputs)
BANK_HIGH, 128, base address of neuron bank B

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  begin inference; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE is exited
done  out  1  one-cycle pulse on completion
result  out  DATA_W  last value written (final-layer last neuron), held until next start
result_base  out  ADDR_W  bank base holding the final layer's outputs
instr_addr  out  ADDR_W  instruction memory address
instr_data  in  ADDR_W  layer size Nk; 0 = end of network (combinational read)
weight_addr  out  ADDR_W  weight ROM address
weight_data  in  DATA_W  signed weight (combinational read)
rd_addr  out  ADDR_W  neuron RAM read address
rd_data  in  DATA_W  signed activation (combinational read)
wr_en  out  1  neuron RAM write strobe
wr_addr  out  ADDR_W  neuron RAM write address
wr_data  out  DATA_W  neuron RAM write data

Behaviour:
- Reset (any time, including mid-inference): state=IDLE. busy, done, wr_en, result, all address outputs, accumulator and counters=0. result_base=BANK_LOW.
- FSM states: IDLE, FETCH_IN, FETCH, MAC, WRITE, DONE. Each state lasts one cycle except MAC.
- IDLE: on start=1 → FETCH_IN. Clear weight pointer and layer index; set read bank=BANK_LOW, write bank=BANK_HIGH.
- FETCH_IN: instr_addr=0; latch instr_data as fan-in (input count); ip=1 → FETCH.
- FETCH: instr_addr=ip.
  - If instr_data==0 or ip>MAX_LAYERS → DONE.
  - Else latch Nk, set neuron=0, i=0, clear accumulator → MAC.
- MAC: lasts fan-in cycles.
  - Each cycle: rd_addr=read_base+i, weight_addr=w_ptr, acc += sign-extended rd_data*weight_data; i++, w_ptr++.
  - After i==fan-in-1 → WRITE. If fan-in==0, go straight to WRITE with acc=0.
- WRITE: compute v = acc >>> FRAC_BITS (arithmetic); if RELU_EN and v<0, v=0; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Drive wr_en=1, wr_addr=write_base+neuron, wr_data=v; result<=v.
  - If neuron<Nk-1: neuron++, i=0, acc=0 → MAC.
  - Else: fan-in<=Nk, swap read/write banks, result_base<=old write_base, ip++ → FETCH.
- DONE: done=1 for exactly one cycle → IDLE. busy deasserts in the same cycle DONE is left.
- start while busy is ignored. Start held high through DONE re-triggers only from IDLE.
- Weight pointer runs continuously across layers; the weight layout is layer-major, neuron-major, input-minor. w_ptr wraps modulo 2^ADDR_W.
- Cycle count from start-accept edge to DONE entry = 1 + Σ_layers(1 + Nk·(fanin+1)) + 1, where the last term is the terminating FETCH.
- No accumulator wrap for valid parameters; the ACC_W width rule guarantees this.

Decomposition:
- Package nn_pkg: FSM state enum, sat_relu function (shift, ReLU, saturate), bank-swap helper, default width constants.
- Sub-module nn_mac_unit: holds the accumulator, the clear/accumulate controls and the sat_relu output stage. The FSM and address counters stay in the top module.

Test Plan:
- FRAC_BITS=0. instr=[2,2,1,0], bankA=[3,4], weights=[1,2,-1,1,2,3] → writes B[0]=11, B[1]=1, then A[0]=25. result=25, result_base=BANK_LOW, done enters DONE 13 cycles after start edge.
- Saturation, FRAC_BITS=0, instr=[2,1,0], inputs [100,100], weights [127,127] → wr_data=127. With weights [-127,-127] and RELU_EN=0 → -128; with RELU_EN=1 → 0.
- FRAC_BITS=4, instr=[1,1,0], input 64, weight 8 → 512>>>4 = 32 written to B[0].
- Empty network instr=[3,0] → no wr_en pulse, done 2 cycles after start edge, result=0.
- Assert reset during second MAC cycle of the first test → busy=0 and wr_en=0 immediately. New start reruns to result=25.
- Pulse start again while busy in the first test → ignored: exactly 3 writes and one done pulse.
